// File: rtl/byte_word_packer.sv
// Packs a strobed byte stream into 16-bit words for the small FIFO, honouring its full flag.
// Optional idle auto-flush of a half word is enabled by defining IDLE_TIMEOUT_FLUSH_EN.
module byte_word_packer #(
    parameter int unsigned LOW_BYTE_FIRST = 1,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
`ifdef IDLE_TIMEOUT_FLUSH_EN
    ,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_strobe,
    input  logic        flush,
    input  logic        fifo_full,
    input  logic        fifo_cleaning,
    output logic [15:0] word_out,
    output logic        en_queue,
    output logic        half_pending,
    output logic        overflow,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HALF      = 2'd1,
        WAIT_FULL = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  held;
    logic [7:0]  held_nxt;
    logic [15:0] word_nxt;
    logic [15:0] count_nxt;
    logic        en_nxt;
    logic        ovf_nxt;
    logic        flush_req;

`ifdef IDLE_TIMEOUT_FLUSH_EN
    logic [15:0] idle_cnt;
    logic [15:0] idle_nxt;
`endif

    // Place the first-received byte in the configured half of the word.
    function automatic logic [15:0] pack(input logic [7:0] first, input logic [7:0] second);
        return (LOW_BYTE_FIRST != 0) ? {second, first} : {first, second};
    endfunction

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        word_nxt  = word_out;
        count_nxt = word_count;
        en_nxt    = 1'b0;
        ovf_nxt   = overflow;
        flush_req = flush;
`ifdef IDLE_TIMEOUT_FLUSH_EN
        idle_nxt = idle_cnt;
        if (byte_strobe) begin
            idle_nxt = 16'd0;
        end else if (state == HALF) begin
            idle_nxt = idle_cnt + 16'd1;
        end
        if ((state == HALF) && (idle_cnt >= (TIMEOUT_CYCLES - 16'd1))) begin
            flush_req = 1'b1;
        end
`endif
        case (state)
            EMPTY: begin
                if (byte_strobe) begin
                    held_nxt  = byte_in;
                    state_nxt = HALF;
                end
            end
            HALF: begin
                // A real second byte takes priority over a pad flush.
                if (byte_strobe || flush_req) begin
                    word_nxt = byte_strobe ? pack(held, byte_in) : pack(held, PAD_BYTE);
                    if (!fifo_full) begin
                        en_nxt    = 1'b1;
                        count_nxt = word_count + 16'd1;
                        state_nxt = GAP;
                    end else begin
                        state_nxt = WAIT_FULL;
                    end
                end
            end
            WAIT_FULL: begin
                if (byte_strobe) begin
                    ovf_nxt = 1'b1;
                end
                if (!fifo_full) begin
                    en_nxt    = 1'b1;
                    count_nxt = word_count + 16'd1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (byte_strobe) begin
                    held_nxt  = byte_in;
                    state_nxt = HALF;
                end else begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State and registered outputs; reset and FIFO clear discard everything.
    always_ff @(posedge clk) begin
        if (reset || fifo_cleaning) begin
            state        <= EMPTY;
            held         <= 8'h00;
            word_out     <= 16'h0000;
            en_queue     <= 1'b0;
            half_pending <= 1'b0;
            overflow     <= 1'b0;
            word_count   <= 16'h0000;
`ifdef IDLE_TIMEOUT_FLUSH_EN
            idle_cnt     <= 16'd0;
`endif
        end else begin
            state        <= state_nxt;
            held         <= held_nxt;
            word_out     <= word_nxt;
            en_queue     <= en_nxt;
            half_pending <= (state_nxt == HALF);
            overflow     <= ovf_nxt;
            word_count   <= count_nxt;
`ifdef IDLE_TIMEOUT_FLUSH_EN
            idle_cnt     <= idle_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer (default build, LOW_BYTE_FIRST=1, PAD_BYTE=00).
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_strobe;
    logic        flush;
    logic        fifo_full;
    logic        fifo_cleaning;
    logic [15:0] word_out;
    logic        en_queue;
    logic        half_pending;
    logic        overflow;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;

    byte_word_packer dut (
        .clk           (clk),
        .reset         (reset),
        .byte_in       (byte_in),
        .byte_strobe   (byte_strobe),
        .flush         (flush),
        .fifo_full     (fifo_full),
        .fifo_cleaning (fifo_cleaning),
        .word_out      (word_out),
        .en_queue      (en_queue),
        .half_pending  (half_pending),
        .overflow      (overflow),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_word"},  word_out,            16'h0000);
        check({tag, "_en"},    16'(en_queue),       16'h0000);
        check({tag, "_half"},  16'(half_pending),   16'h0000);
        check({tag, "_ovf"},   16'(overflow),       16'h0000);
        check({tag, "_count"}, word_count,          16'h0000);
    endtask

    initial begin
        logic seen_en;
        reset = 1'b1; byte_in = 8'h00; byte_strobe = 1'b0; flush = 1'b0;
        fifo_full = 1'b0; fifo_cleaning = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_zero("rst");

        // T1: two bytes, low byte first
        byte_strobe = 1'b1; byte_in = 8'h34; tick();
        check("t1_half", 16'(half_pending), 16'h0001);
        check("t1_en0",  16'(en_queue),     16'h0000);
        byte_in = 8'h12; tick();
        check("t1_en",    16'(en_queue),     16'h0001);
        check("t1_word",  word_out,          16'h1234);
        check("t1_count", word_count,        16'h0001);
        check("t1_half0", 16'(half_pending), 16'h0000);
        byte_strobe = 1'b0; tick();
        check("t1_pulse", 16'(en_queue), 16'h0000);
        check("t1_hold",  word_out,      16'h1234);

        // T2: back-to-back strobes 01..08
        for (int i = 0; i < 8; i++) begin
            byte_strobe = 1'b1; byte_in = 8'(i + 1); tick();
            check($sformatf("t2_en%0d", i), 16'(en_queue), 16'(i % 2));
            if (i % 2 == 1) check($sformatf("t2_word%0d", i), word_out, {8'(i + 1), 8'(i)});
        end
        byte_strobe = 1'b0; tick();
        check("t2_count", word_count,      16'h0005);
        check("t2_ovf",   16'(overflow),   16'h0000);

        // T3: FIFO full, dropped byte during hold
        fifo_full = 1'b1;
        byte_strobe = 1'b1; byte_in = 8'hEF; tick();
        byte_in = 8'hBE; tick();
        check("t3_en_blk", 16'(en_queue), 16'h0000);
        check("t3_word",   word_out,      16'hBEEF);
        byte_in = 8'h55; tick();
        byte_strobe = 1'b0;
        check("t3_ovf", 16'(overflow), 16'h0001);
        seen_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_en = seen_en | en_queue;
        end
        check("t3_no_en", 16'(seen_en), 16'h0000);
        fifo_full = 1'b0; tick();
        check("t3_en",    16'(en_queue), 16'h0001);
        check("t3_word2", word_out,      16'hBEEF);
        check("t3_count", word_count,    16'h0006);
        tick();
        check("t3_half",  16'(half_pending), 16'h0000);
        check("t3_count2", word_count,       16'h0006);
        check("t3_ovf2",  16'(overflow),     16'h0001);

        // T4: single byte then flush pads the high half
        byte_strobe = 1'b1; byte_in = 8'hA5; tick();
        byte_strobe = 1'b0; flush = 1'b1; tick();
        check("t4_en",    16'(en_queue), 16'h0001);
        check("t4_word",  word_out,      16'h00A5);
        check("t4_count", word_count,    16'h0007);
        flush = 1'b0; tick();
        byte_strobe = 1'b1; byte_in = 8'hA5; tick();
        byte_strobe = 1'b0;
        seen_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_en = seen_en | en_queue;
        end
        check("t4_no_timeout", 16'(seen_en),      16'h0000);
        check("t4_half",       16'(half_pending), 16'h0001);
        flush = 1'b1; tick();
        flush = 1'b0;
        check("t4_word2",  word_out,   16'h00A5);
        check("t4_count2", word_count, 16'h0008);
        tick();

        // T5: reset in WAIT_FULL
        byte_strobe = 1'b1; byte_in = 8'h77; tick();
        fifo_full = 1'b1; byte_in = 8'h88; tick();
        check("t5_word", word_out, 16'h8877);
        byte_strobe = 1'b0; reset = 1'b1; tick();
        check_zero("t5_rst");
        reset = 1'b0; fifo_full = 1'b0; tick();
        check("t5_rst_en", 16'(en_queue), 16'h0000);
        byte_strobe = 1'b1; byte_in = 8'h01; tick();
        byte_in = 8'h02; tick();
        byte_in = 8'h03; tick();
        fifo_full = 1'b1; byte_in = 8'h04; tick();
        byte_in = 8'h05; tick();
        check("t5_ovf_pre",   16'(overflow), 16'h0001);
        check("t5_count_pre", word_count,    16'h0001);
        byte_strobe = 1'b0; fifo_cleaning = 1'b1; tick();
        check_zero("t5_clr");
        fifo_cleaning = 1'b0; fifo_full = 1'b0; tick();
        check("t5_clr_en", 16'(en_queue), 16'h0000);

        // T6: second strobe with flush yields one word only
        byte_strobe = 1'b1; byte_in = 8'h11; tick();
        byte_in = 8'h22; flush = 1'b1; tick();
        check("t6_en",   16'(en_queue), 16'h0001);
        check("t6_word", word_out,      16'h2211);
        byte_strobe = 1'b0; flush = 1'b0; tick();
        check("t6_en0", 16'(en_queue), 16'h0000);
        tick();
        check("t6_en1",   16'(en_queue),     16'h0000);
        check("t6_count", word_count,        16'h0001);
        check("t6_half",  16'(half_pending), 16'h0000);
        check("t6_word2", word_out,          16'h2211);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
